// File: rtl/perf_stat_counter.sv
// perf_stat_counter
//   Performance-statistics unit. Counts cycles, retired instructions, ICache
//   requests/hits and DCache requests/hits. All counting stops once a HALT
//   retires, until clr or reset. Counters are read through a registered
//   select/read port.
//
//   Build option: PERF_SATURATE_EN
//     defined   : counters saturate at all-ones; ovf set on the blocked increment
//     undefined : counters wrap modulo 2^CNT_W; ovf set on the wrapping increment
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous clear of counters, ovf and halted state
//   wb_regwrite,
//   wb_memwrite,
//   wb_halt             retire strobes from writeback
//   icache_req/hit      ICache request and hit (hit qualified by req)
//   dcache_req/hit      DCache request and hit (hit qualified by req)
//   rd_en, rd_sel       read strobe and counter select (0..5, 6/7 read as 0)
//   rd_data, rd_valid   registered read data, one-cycle valid pulse
//   halted              counters frozen after a HALT
//   ovf                 sticky per-counter overflow, bit index = rd_sel

module perf_stat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wb_regwrite,
    input  logic             wb_memwrite,
    input  logic             wb_halt,
    input  logic             icache_req,
    input  logic             icache_hit,
    input  logic             dcache_req,
    input  logic             dcache_hit,
    input  logic             rd_en,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             halted,
    output logic [5:0]       ovf
);

    // state   | meaning
    // ST_RUN  | counters advance on their events
    // ST_HALT | a HALT retired; every counter is frozen until clr or reset
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } stateT;

    localparam int NCNT = 6;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stateT             state;
    stateT             stateNext;
    logic              active;
    logic [NCNT-1:0]   evt;
    logic [CNT_W-1:0]  cnt [NCNT];
    logic [CNT_W-1:0]  selData;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        // clr wins over a HALT retiring in the same cycle
        if (clr) begin
            stateNext = ST_RUN;
        end else if (state == ST_RUN && wb_halt) begin
            stateNext = ST_HALT;
        end
    end

    assign halted = (state == ST_HALT);
    // The HALT cycle itself is still active; freezing starts the edge after.
    assign active = ~clr & (state == ST_RUN);

    // ------------------------------------------------------------- events
    always_comb begin
        evt    = '0;
        evt[0] = 1'b1;
        evt[1] = wb_regwrite | wb_memwrite | wb_halt;
        evt[2] = icache_req;
        evt[3] = icache_req & icache_hit;
        evt[4] = dcache_req;
        evt[5] = dcache_req & dcache_hit;
    end

    // ----------------------------------------------------------- counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else if (clr) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else if (active) begin
            for (int i = 0; i < NCNT; i++) begin
                if (evt[i]) begin
                    if (&cnt[i]) begin
                        ovf[i] <= 1'b1;
`ifdef PERF_SATURATE_EN
                        cnt[i] <= cnt[i];
`else
                        cnt[i] <= '0;
`endif
                    end else begin
                        cnt[i] <= cnt[i] + ONE;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------- read port
    always_comb begin
        selData = '0;
        case (rd_sel)
            3'd0:    selData = cnt[0];
            3'd1:    selData = cnt[1];
            3'd2:    selData = cnt[2];
            3'd3:    selData = cnt[3];
            3'd4:    selData = cnt[4];
            3'd5:    selData = cnt[5];
            default: selData = '0;
        endcase
    end

    // Sampled from the pre-edge counter values, so a read reports the count
    // before any increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= selData;
            end
        end
    end

endmodule
